// File: rtl/uart_pkg.sv
// Shared constants for the UART AXI-Lite register bank: register offsets,
// STATUS/CTRL bit positions, AXI response codes and the TX launch FSM encoding.
package uart_pkg;

  localparam logic [3:0] ADDR_TXDATA = 4'h0;
  localparam logic [3:0] ADDR_RXDATA = 4'h4;
  localparam logic [3:0] ADDR_STATUS = 4'h8;
  localparam logic [3:0] ADDR_CTRL   = 4'hC;

  localparam int STAT_RX_VALID = 0;
  localparam int STAT_TX_BUSY  = 1;
  localparam int STAT_OVERRUN  = 2;
  localparam int STAT_RX_BUSY  = 3;

  localparam int CTRL_W          = 18;
  localparam int CTRL_RX_IRQ_EN  = 16;
  localparam int CTRL_OVR_IRQ_EN = 17;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_PEND = 2'd1,
    TX_WAIT = 2'd2
  } tx_state_e;

  localparam int TX_WAIT_TIMEOUT = 4;

  // Register select is the word index within the 16-byte window.
  function automatic logic [1:0] reg_index(input logic [3:0] addr);
    return addr[3:2];
  endfunction

endpackage

// File: rtl/uart_axil_if.sv
// AXI4-Lite slave handshake: latches AW/W beats independently, issues one
// write strobe per transaction and registers read data until accepted.
module uart_axil_if
  import uart_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [31:0]           s_axil_wdata,
  input  logic [3:0]            s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [31:0]           s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [31:0]           wr_data_o,
  output logic [3:0]            wr_strb_o,
  input  logic [1:0]            wr_resp_i,
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  input  logic [31:0]           rd_data_i
);

  logic                  awready_q, awready_d, aw_held_q, aw_held_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic                  wready_q, wready_d, w_held_q, w_held_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  aw_hs, w_hs, ar_hs, wr_fire;

  always_comb begin
    aw_hs   = s_axil_awvalid & awready_q;
    w_hs    = s_axil_wvalid & wready_q;
    ar_hs   = s_axil_arvalid & arready_q;
    wr_fire = aw_held_q & w_held_q & ~bvalid_q;

    // Ready is a single-cycle pulse; a latched beat or an unacknowledged
    // response blocks further acceptance on that channel.
    awready_d = s_axil_awvalid & ~awready_q & ~aw_held_q & ~bvalid_q;
    wready_d  = s_axil_wvalid & ~wready_q & ~w_held_q & ~bvalid_q;
    arready_d = s_axil_arvalid & ~arready_q & ~rvalid_q;

    aw_held_d = wr_fire ? 1'b0 : (aw_held_q | aw_hs);
    w_held_d  = wr_fire ? 1'b0 : (w_held_q | w_hs);
    awaddr_d  = aw_hs ? s_axil_awaddr : awaddr_q;
    wdata_d   = w_hs ? s_axil_wdata : wdata_q;
    wstrb_d   = w_hs ? s_axil_wstrb : wstrb_q;

    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    if (wr_fire) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_resp_i;
    end else if (bvalid_q && s_axil_bready) begin
      bvalid_d = 1'b0;
    end

    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_data_i;
    end else if (rvalid_q && s_axil_rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      awready_q <= 1'b0;
      aw_held_q <= 1'b0;
      awaddr_q  <= '0;
      wready_q  <= 1'b0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      awready_q <= awready_d;
      aw_held_q <= aw_held_d;
      awaddr_q  <= awaddr_d;
      wready_q  <= wready_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

  assign s_axil_awready = awready_q;
  assign s_axil_wready  = wready_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_arready = arready_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = RESP_OKAY;

  assign wr_en_o   = wr_fire;
  assign wr_addr_o = awaddr_q;
  assign wr_data_o = wdata_q;
  assign wr_strb_o = wstrb_q;
  assign rd_en_o   = ar_hs;
  assign rd_addr_o = s_axil_araddr;

endmodule

// File: rtl/uart_axil_regs.sv
// UART register bank: TX launch FSM, one-byte RX holding register with
// overrun detection, prescale/IRQ-enable control and a registered level IRQ.
module uart_axil_regs
  import uart_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [31:0]           s_axil_wdata,
  input  logic [3:0]            s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [31:0]           s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_start,
  input  logic                  tx_busy,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_ready,
  input  logic                  rx_busy,
  output logic [15:0]           prescale,
  output logic                  irq
);

  localparam logic [1:0] SEL_TXDATA = reg_index(ADDR_TXDATA);
  localparam logic [1:0] SEL_RXDATA = reg_index(ADDR_RXDATA);
  localparam logic [1:0] SEL_STATUS = reg_index(ADDR_STATUS);
  localparam int         TX_CNT_W   = $clog2(TX_WAIT_TIMEOUT);
  localparam logic [TX_CNT_W-1:0] TX_CNT_LAST = TX_CNT_W'(TX_WAIT_TIMEOUT - 1);

  logic                  wr_en, rd_en;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic [31:0]           wr_data, rd_data;
  logic [3:0]            wr_strb;
  logic [1:0]            wr_resp, wr_sel, rd_sel;
  logic                  tx_wr, ovr_clr, rx_pop;

  logic [CTRL_W-1:0]     ctrl_q, ctrl_d;
  tx_state_e             tx_state_q, tx_state_d;
  logic [TX_CNT_W-1:0]   tx_cnt_q, tx_cnt_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_start_q, tx_start_d;
  logic [DATA_WIDTH-1:0] rx_byte_q, rx_byte_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  overrun_q, overrun_d;
  logic                  irq_q, irq_d;

  uart_axil_if #(.ADDR_WIDTH(ADDR_WIDTH)) u_if (
    .clk            (clk),
    .rst            (rst),
    .s_axil_awaddr  (s_axil_awaddr),
    .s_axil_awvalid (s_axil_awvalid),
    .s_axil_awready (s_axil_awready),
    .s_axil_wdata   (s_axil_wdata),
    .s_axil_wstrb   (s_axil_wstrb),
    .s_axil_wvalid  (s_axil_wvalid),
    .s_axil_wready  (s_axil_wready),
    .s_axil_bresp   (s_axil_bresp),
    .s_axil_bvalid  (s_axil_bvalid),
    .s_axil_bready  (s_axil_bready),
    .s_axil_araddr  (s_axil_araddr),
    .s_axil_arvalid (s_axil_arvalid),
    .s_axil_arready (s_axil_arready),
    .s_axil_rdata   (s_axil_rdata),
    .s_axil_rresp   (s_axil_rresp),
    .s_axil_rvalid  (s_axil_rvalid),
    .s_axil_rready  (s_axil_rready),
    .wr_en_o        (wr_en),
    .wr_addr_o      (wr_addr),
    .wr_data_o      (wr_data),
    .wr_strb_o      (wr_strb),
    .wr_resp_i      (wr_resp),
    .rd_en_o        (rd_en),
    .rd_addr_o      (rd_addr),
    .rd_data_i      (rd_data)
  );

  assign wr_sel = reg_index(wr_addr[3:0]);
  assign rd_sel = reg_index(rd_addr[3:0]);
  assign rx_pop = rd_en && (rd_sel == SEL_RXDATA);

  always_comb begin
    ctrl_d  = ctrl_q;
    wr_resp = RESP_OKAY;
    tx_wr   = 1'b0;
    ovr_clr = 1'b0;
    if (wr_en) begin
      case (wr_sel)
        SEL_TXDATA: begin
          if (tx_state_q != TX_IDLE) wr_resp = RESP_SLVERR;
          else                       tx_wr   = wr_strb[0];
        end
        SEL_RXDATA: wr_resp = RESP_SLVERR;
        SEL_STATUS: ovr_clr = wr_strb[0] & wr_data[STAT_OVERRUN];
        default: begin
          if (wr_strb[0]) ctrl_d[7:0]   = wr_data[7:0];
          if (wr_strb[1]) ctrl_d[15:8]  = wr_data[15:8];
          if (wr_strb[2]) ctrl_d[CTRL_OVR_IRQ_EN:CTRL_RX_IRQ_EN] =
                            wr_data[CTRL_OVR_IRQ_EN:CTRL_RX_IRQ_EN];
        end
      endcase
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_wr) begin
          tx_data_d  = wr_data[DATA_WIDTH-1:0];
          tx_state_d = TX_PEND;
        end
      end
      TX_PEND: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_cnt_d   = '0;
          tx_state_d = TX_WAIT;
        end
      end
      TX_WAIT: begin
        // Give up waiting for busy after a few cycles so a silent core cannot wedge us.
        if (tx_busy || tx_cnt_q == TX_CNT_LAST) tx_state_d = TX_IDLE;
        else                                    tx_cnt_d   = tx_cnt_q + 1'b1;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    rx_byte_d  = rx_byte_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    if (ovr_clr) overrun_d = 1'b0;
    // A byte arriving alongside a pop replaces the popped one without overrun.
    if (rx_ready) begin
      rx_byte_d  = rx_data;
      rx_valid_d = 1'b1;
      if (rx_valid_q && !rx_pop) overrun_d = 1'b1;
    end else if (rx_pop) begin
      rx_valid_d = 1'b0;
    end
    irq_d = (rx_valid_q & ctrl_q[CTRL_RX_IRQ_EN]) | (overrun_q & ctrl_q[CTRL_OVR_IRQ_EN]);
  end

  always_comb begin
    rd_data = '0;
    case (rd_sel)
      SEL_RXDATA: rd_data = 32'({rx_valid_q, rx_byte_q});
      SEL_STATUS: begin
        rd_data[STAT_RX_VALID] = rx_valid_q;
        rd_data[STAT_TX_BUSY]  = tx_busy | (tx_state_q != TX_IDLE);
        rd_data[STAT_OVERRUN]  = overrun_q;
        rd_data[STAT_RX_BUSY]  = rx_busy;
      end
      SEL_TXDATA: rd_data = '0;
      default:    rd_data = 32'(ctrl_q);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q     <= '0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
      irq_q      <= irq_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign prescale = ctrl_q[15:0];
  assign irq      = irq_q;

endmodule

// File: tb/tb_uart_axil_regs.sv
// Self-checking bench for uart_axil_regs: directed scenarios plus a randomized
// register-level phase compared against a simple behavioural model.
module tb_uart_axil_regs;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  s_axil_awaddr;
  logic        s_axil_awvalid, s_axil_awready;
  logic [31:0] s_axil_wdata;
  logic [3:0]  s_axil_wstrb;
  logic        s_axil_wvalid, s_axil_wready;
  logic [1:0]  s_axil_bresp;
  logic        s_axil_bvalid, s_axil_bready;
  logic [3:0]  s_axil_araddr;
  logic        s_axil_arvalid, s_axil_arready;
  logic [31:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic        s_axil_rvalid, s_axil_rready;
  logic [7:0]  tx_data;
  logic        tx_start, tx_busy;
  logic [7:0]  rx_data;
  logic        rx_ready, rx_busy;
  logic [15:0] prescale;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;
  int start_cnt = 0;
  logic [7:0] last_tx = 8'h00;

  always #5 clk = ~clk;

  uart_axil_regs #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
    .s_axil_wready(s_axil_wready), .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
    .s_axil_bready(s_axil_bready), .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid),
    .s_axil_arready(s_axil_arready), .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_ready(rx_ready), .rx_busy(rx_busy),
    .prescale(prescale), .irq(irq)
  );

  // Every cycle tx_start is high counts as one launch; a clean pulse counts once.
  always @(negedge clk) begin
    if (tx_start) begin
      start_cnt = start_cnt + 1;
      last_tx   = tx_data;
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           input bit hold_b, output logic [1:0] resp);
    bit aw_hs, w_hs, b_hs, done;
    int n;
    aw_hs = 0; w_hs = 0; b_hs = 0; done = 0; n = 0; resp = 2'b11;
    s_axil_awaddr = a; s_axil_awvalid = 1'b1;
    s_axil_wdata = d; s_axil_wstrb = s; s_axil_wvalid = 1'b1;
    s_axil_bready = !hold_b;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (aw_hs) begin s_axil_awvalid = 1'b0; aw_hs = 0; end
      if (w_hs)  begin s_axil_wvalid = 1'b0;  w_hs = 0;  end
      if (b_hs) begin
        s_axil_bready = 1'b0;
        done = 1;
      end else begin
        if (s_axil_awvalid && s_axil_awready) aw_hs = 1;
        if (s_axil_wvalid && s_axil_wready)   w_hs = 1;
        if (s_axil_bvalid) begin
          resp = s_axil_bresp;
          if (hold_b) done = 1; else b_hs = 1;
        end
      end
    end
    chk_eq("wr_done", 32'(done), 32'd1);
    if (!done) begin
      s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_bready = 1'b0;
    end
    $display("wr addr=0x%h data=0x%08h strb=%b resp=%b", a, d, s, resp);
  endtask

  task automatic axi_read(input logic [3:0] a, input bit hold_r, input bit inject,
                          input logic [7:0] inj_byte, output logic [31:0] data);
    bit ar_hs, r_hs, done;
    int n;
    ar_hs = 0; r_hs = 0; done = 0; n = 0; data = 32'hDEAD_BEEF;
    s_axil_araddr = a; s_axil_arvalid = 1'b1; s_axil_rready = !hold_r;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (ar_hs) begin s_axil_arvalid = 1'b0; rx_ready = 1'b0; ar_hs = 0; end
      if (r_hs) begin
        s_axil_rready = 1'b0;
        done = 1;
      end else begin
        if (s_axil_arvalid && s_axil_arready) begin
          ar_hs = 1;
          if (inject) begin rx_data = inj_byte; rx_ready = 1'b1; end
        end
        if (s_axil_rvalid) begin
          data = s_axil_rdata;
          chk_eq("rresp", 32'(s_axil_rresp), 32'(RESP_OKAY));
          if (hold_r) done = 1; else r_hs = 1;
        end
      end
    end
    chk_eq("rd_done", 32'(done), 32'd1);
    if (!done) begin s_axil_arvalid = 1'b0; s_axil_rready = 1'b0; end
    $display("rd addr=0x%h data=0x%08h", a, data);
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    @(negedge clk);
    rx_data = b; rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    @(negedge clk);
    $display("rx byte=0x%02h", b);
  endtask

  task automatic chk_all_zero(input string tag);
    chk_eq({tag, "_hs"}, 32'({s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_arready,
                              s_axil_rvalid, tx_start, irq}), 32'd0);
    chk_eq({tag, "_resp"}, 32'({s_axil_bresp, s_axil_rresp}), 32'd0);
    chk_eq({tag, "_rdata"}, s_axil_rdata, 32'd0);
    chk_eq({tag, "_txd_pre"}, 32'({tx_data, prescale}), 32'd0);
  endtask

  logic [1:0]  resp;
  logic [31:0] rd;
  int          s0;
  logic [17:0] m_ctrl;
  bit          m_valid, m_ovr;
  logic [7:0]  m_byte;
  logic [31:0] d;
  logic [3:0]  s;
  logic [7:0]  b;

  initial begin
    rst = 1'b1;
    s_axil_awaddr = '0; s_axil_awvalid = 0; s_axil_wdata = '0; s_axil_wstrb = '0;
    s_axil_wvalid = 0; s_axil_bready = 0; s_axil_araddr = '0; s_axil_arvalid = 0;
    s_axil_rready = 0; tx_busy = 0; rx_data = '0; rx_ready = 0; rx_busy = 0;
    idle(3);
    chk_all_zero("reset");
    rst = 1'b0;
    idle(2);

    // Reset values readable over the bus
    axi_read(ADDR_STATUS, 0, 0, 8'h00, rd); chk_eq("rst_status", rd, 32'h0);
    axi_read(ADDR_CTRL, 0, 0, 8'h00, rd);   chk_eq("rst_ctrl", rd, 32'h0);
    chk_eq("rst_irq", 32'(irq), 32'd0);

    // CTRL write, read-back and byte-lane masking
    axi_write(ADDR_CTRL, 32'h0001_01B2, 4'hF, 0, resp);
    chk_eq("ctrl_resp", 32'(resp), 32'(RESP_OKAY));
    chk_eq("prescale_1b2", 32'(prescale), 32'h01B2);
    axi_read(ADDR_CTRL, 0, 0, 8'h00, rd);   chk_eq("ctrl_rb", rd, 32'h0001_01B2);
    axi_write(ADDR_CTRL, 32'hFFFF_FFFF, 4'b0001, 0, resp);
    chk_eq("prescale_lane0", 32'(prescale), 32'h01FF);
    axi_read(ADDR_CTRL, 0, 0, 8'h00, rd);   chk_eq("ctrl_rb2", rd, 32'h0001_01FF);

    // TX launch, then writes while the core reports busy
    s0 = start_cnt;
    axi_write(ADDR_TXDATA, 32'h55, 4'hF, 0, resp);
    chk_eq("tx1_resp", 32'(resp), 32'(RESP_OKAY));
    idle(6);
    chk_eq("tx1_pulses", 32'(start_cnt - s0), 32'd1);
    chk_eq("tx1_data", 32'(last_tx), 32'h55);
    tx_busy = 1'b1;
    axi_write(ADDR_TXDATA, 32'h66, 4'hF, 0, resp);
    chk_eq("tx2_resp", 32'(resp), 32'(RESP_OKAY));
    idle(3);
    axi_write(ADDR_TXDATA, 32'h77, 4'hF, 0, resp);
    chk_eq("tx3_slverr", 32'(resp), 32'(RESP_SLVERR));
    axi_read(ADDR_STATUS, 0, 0, 8'h00, rd); chk_eq("tx_busy_stat", rd, 32'h2);
    chk_eq("tx_data_hold", 32'(tx_data), 32'h66);
    chk_eq("tx_no_extra", 32'(start_cnt - s0), 32'd1);
    tx_busy = 1'b0;
    idle(8);
    chk_eq("tx2_pulses", 32'(start_cnt - s0), 32'd2);
    chk_eq("tx2_data", 32'(last_tx), 32'h66);
    axi_read(ADDR_STATUS, 0, 0, 8'h00, rd); chk_eq("tx_idle_stat", rd, 32'h0);

    // RX capture and interrupt
    rx_pulse(8'hA3);
    chk_eq("rx_irq_on", 32'(irq), 32'd1);
    axi_read(ADDR_RXDATA, 0, 0, 8'h00, rd); chk_eq("rx_a3", rd, 32'h1A3);
    axi_read(ADDR_STATUS, 0, 0, 8'h00, rd); chk_eq("rx_popped", rd, 32'h0);
    chk_eq("rx_irq_off", 32'(irq), 32'd0);

    // Overrun, W1C clear, and a byte arriving on the pop cycle
    rx_pulse(8'h11);
    rx_pulse(8'h22);
    axi_read(ADDR_STATUS, 0, 0, 8'h00, rd); chk_eq("ovr_stat", rd, 32'h5);
    axi_read(ADDR_RXDATA, 0, 0, 8'h00, rd); chk_eq("ovr_byte", rd, 32'h122);
    axi_write(ADDR_STATUS, 32'h4, 4'hF, 0, resp);
    chk_eq("w1c_resp", 32'(resp), 32'(RESP_OKAY));
    axi_read(ADDR_STATUS, 0, 0, 8'h00, rd); chk_eq("ovr_cleared", rd, 32'h0);
    rx_pulse(8'h33);
    axi_read(ADDR_RXDATA, 0, 1, 8'h44, rd); chk_eq("pop_same_cyc", rd, 32'h133);
    axi_read(ADDR_STATUS, 0, 0, 8'h00, rd); chk_eq("pop_no_ovr", rd, 32'h1);
    axi_read(ADDR_RXDATA, 0, 0, 8'h00, rd); chk_eq("pop_new_byte", rd, 32'h144);

    // Randomized register traffic against the model
    rst = 1'b1; idle(2); rst = 1'b0; idle(1);
    m_ctrl = '0; m_valid = 0; m_ovr = 0; m_byte = '0;
    for (int it = 0; it < 60; it++) begin
      int op;
      op = $urandom_range(0, 8);
      rx_busy = 1'($urandom_range(0, 1));
      case (op)
        0: begin
          d = $urandom; s = 4'($urandom_range(0, 15));
          axi_write(ADDR_CTRL, d, s, 0, resp);
          chk_eq("r_ctrl_resp", 32'(resp), 32'(RESP_OKAY));
          if (s[0]) m_ctrl[7:0]   = d[7:0];
          if (s[1]) m_ctrl[15:8]  = d[15:8];
          if (s[2]) m_ctrl[17:16] = d[17:16];
          chk_eq("r_prescale", 32'(prescale), 32'(m_ctrl[15:0]));
        end
        1: begin
          axi_read(ADDR_CTRL, 0, 0, 8'h00, rd); chk_eq("r_ctrl", rd, 32'(m_ctrl));
        end
        2: begin
          axi_read(ADDR_STATUS, 0, 0, 8'h00, rd);
          chk_eq("r_status", rd, 32'({rx_busy, m_ovr, 1'b0, m_valid}));
        end
        3: begin
          b = 8'($urandom);
          rx_pulse(b);
          if (m_valid) m_ovr = 1;
          m_valid = 1; m_byte = b;
        end
        4: begin
          axi_read(ADDR_RXDATA, 0, 0, 8'h00, rd);
          chk_eq("r_rxdata", rd, 32'({m_valid, m_byte}));
          m_valid = 0;
        end
        5: begin
          d = $urandom & 32'hFFFF_FFF3; d[2] = 1'($urandom_range(0, 1));
          s = 4'($urandom_range(0, 15));
          axi_write(ADDR_STATUS, d, s, 0, resp);
          chk_eq("r_w1c_resp", 32'(resp), 32'(RESP_OKAY));
          if (s[0] && d[2]) m_ovr = 0;
        end
        6: begin
          d = $urandom; s = 4'($urandom_range(0, 15)); s0 = start_cnt;
          axi_write(ADDR_TXDATA, d, s, 0, resp);
          chk_eq("r_tx_resp", 32'(resp), 32'(RESP_OKAY));
          idle(8);
          chk_eq("r_tx_pulses", 32'(start_cnt - s0), 32'(s[0]));
          if (s[0]) chk_eq("r_tx_data", 32'(last_tx), 32'(d[7:0]));
        end
        7: begin
          axi_write(ADDR_RXDATA, $urandom, 4'hF, 0, resp);
          chk_eq("r_rxw_slverr", 32'(resp), 32'(RESP_SLVERR));
        end
        default: begin
          axi_read(ADDR_TXDATA, 0, 0, 8'h00, rd); chk_eq("r_txdata_rd", rd, 32'h0);
        end
      endcase
      chk_eq("r_irq", 32'(irq), 32'((m_valid & m_ctrl[16]) | (m_ovr & m_ctrl[17])));
    end
    rx_busy = 1'b0;

    // Held responses stay stable, then reset mid-transfer discards everything
    idle(8);
    axi_write(ADDR_CTRL, 32'h0001_0000, 4'hF, 0, resp);
    axi_read(ADDR_RXDATA, 0, 0, 8'h00, rd);
    tx_busy = 1'b1;
    rx_pulse(8'h5A);
    axi_write(ADDR_TXDATA, 32'hC3, 4'hF, 0, resp);
    chk_eq("pend_resp", 32'(resp), 32'(RESP_OKAY));
    chk_eq("pend_txdata", 32'(tx_data), 32'hC3);
    chk_eq("pend_irq", 32'(irq), 32'd1);
    s0 = start_cnt;
    axi_write(ADDR_RXDATA, 32'h0, 4'hF, 1, resp);
    chk_eq("hold_bresp0", 32'(resp), 32'(RESP_SLVERR));
    axi_read(ADDR_CTRL, 1, 0, 8'h00, rd);
    chk_eq("hold_rdata0", rd, 32'h0001_0000);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk_eq("hold_b", 32'({s_axil_bvalid, s_axil_bresp}), 32'({1'b1, RESP_SLVERR}));
      chk_eq("hold_r", 32'({s_axil_rvalid, s_axil_rdata}), {1'b1, 32'h0001_0000} & 33'h1_FFFF_FFFF);
    end
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("midrst");
    idle(1);
    rst = 1'b0;
    tx_busy = 1'b0;
    idle(8);
    chk_eq("midrst_no_tx", 32'(start_cnt - s0), 32'd0);
    axi_read(ADDR_STATUS, 0, 0, 8'h00, rd); chk_eq("midrst_status", rd, 32'h0);
    axi_read(ADDR_RXDATA, 0, 0, 8'h00, rd); chk_eq("midrst_rxdata", rd, 32'h0);
    axi_read(ADDR_CTRL, 0, 0, 8'h00, rd);   chk_eq("midrst_ctrl", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
